// File: rtl/shift_ring_pkg.sv
// -----------------------------------------------------------------------------
// shift_ring_pkg
// Shared definitions for the ring / Johnson counter:
//   MODE_RING / MODE_JOHNSON  - encoding of the run-time mode bit
//   start_pattern(mode)       - state the counter restarts from
//   is_legal(q, width, mode)  - legality check for a state of the given width
// Vectors are carried at MAX_W bits so the helpers stay width-agnostic.
// Callers zero-extend into them and truncate out of them.
// -----------------------------------------------------------------------------
package shift_ring_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam int   MAX_W        = 32;

  // Ring restarts at a single 1 in bit 0; Johnson restarts at all zeros.
  function automatic logic [MAX_W-1:0] start_pattern(input logic mode);
    return (mode == MODE_JOHNSON) ? '0 : MAX_W'(1);
  endfunction

  // Ring: exactly one bit set.
  // Johnson: at most two bit changes around the circular bit order.
  function automatic logic is_legal(input logic [MAX_W-1:0] q,
                                    input int               width,
                                    input logic             mode);
    int ones;
    int edges;
    int j;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        j      = (i + 1 >= width) ? 0 : i + 1;
        ones  += int'(q[i]);
        edges += int'(q[i] ^ q[j]);
      end
    end
    return (mode == MODE_JOHNSON) ? (edges <= 2) : (ones == 1);
  endfunction

endpackage

// File: rtl/shift_ring_counter_if.sv
// -----------------------------------------------------------------------------
// shift_ring_counter_if
// Control and status bundle of shift_ring_counter.
//   en, dir, mode, load, load_val : controls, driven by the master
//   q, qbar, idx, wrap, err       : counter status, driven by the slave (counter)
// -----------------------------------------------------------------------------
interface shift_ring_counter_if #(
  parameter int WIDTH = 4
);
  localparam int IDX_W = $clog2(2 * WIDTH);

  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [IDX_W-1:0] idx;
  logic             wrap;
  logic             err;

  modport master (
    output en, dir, mode, load, load_val,
    input  q, qbar, idx, wrap, err
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output q, qbar, idx, wrap, err
  );

endinterface

// File: rtl/ring_state_decode.sv
// -----------------------------------------------------------------------------
// ring_state_decode
// Combinational decode of a counter state.
//   q     in  WIDTH  state to decode
//   mode  in  1      MODE_RING / MODE_JOHNSON
//   legal out 1      state is legal for mode
//   idx   out IDX_W  phase index (0 when the state is illegal)
// -----------------------------------------------------------------------------
module ring_state_decode
  import shift_ring_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  int ones_c;
  int pos_c;

  always_comb begin
    ones_c = 0;
    pos_c  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_c += int'(q[i]);
      if (q[i]) pos_c = i;
    end
  end

  always_comb begin
    legal = is_legal(MAX_W'(q), WIDTH, mode);
    idx   = '0;
    if (legal) begin
      if (mode == MODE_RING)
        idx = IDX_W'(pos_c);
      // Johnson fills with ones for the first WIDTH phases, then drains them.
      else if (q[WIDTH-1])
        idx = IDX_W'(2 * WIDTH - ones_c);
      else
        idx = IDX_W'(ones_c);
    end
  end

endmodule

// File: rtl/shift_ring_counter.sv
// -----------------------------------------------------------------------------
// shift_ring_counter
// One-hot ring / Johnson counter with run-time mode and direction, enable,
// parallel load, illegal-state recovery, phase index and wrap pulse.
//   clk  in  1  clock, rising edge
//   rst  in  1  synchronous active-high reset
//   bus  slave modport of shift_ring_counter_if
//        (en, dir, mode, load, load_val in; q, qbar, idx, wrap, err out)
// Per-edge priority: rst > load > mode change > illegal recovery > step > hold.
// -----------------------------------------------------------------------------
module shift_ring_counter
  import shift_ring_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_ring_counter_if.slave bus
);

  localparam int IDX_W = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] start_cur;
  logic [WIDTH-1:0] start_new;
  logic             q_legal;
  logic             load_legal;
  logic [IDX_W-1:0] idx_c;
  logic [IDX_W-1:0] load_idx_unused;

  ring_state_decode #(.WIDTH(WIDTH)) u_dec_q (
    .q     (q_q),
    .mode  (mode_q),
    .legal (q_legal),
    .idx   (idx_c)
  );

  // Loads are judged against the mode the counter is currently running in.
  ring_state_decode #(.WIDTH(WIDTH)) u_dec_load (
    .q     (bus.load_val),
    .mode  (mode_q),
    .legal (load_legal),
    .idx   (load_idx_unused)
  );

  assign start_cur = WIDTH'(start_pattern(mode_q));
  assign start_new = WIDTH'(start_pattern(bus.mode));

  // Johnson differs from ring only by inverting the bit fed back around.
  always_comb begin
    step_val = q_q;
    if (!bus.dir)
      step_val = {q_q[WIDTH-2:0],
                  (mode_q == MODE_JOHNSON) ? ~q_q[WIDTH-1] : q_q[WIDTH-1]};
    else
      step_val = {(mode_q == MODE_JOHNSON) ? ~q_q[0] : q_q[0],
                  q_q[WIDTH-1:1]};
  end

  always_comb begin
    q_d    = q_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.load) begin
      if (load_legal) q_d   = bus.load_val;
      else            err_d = 1'b1;
    end else if (bus.mode != mode_q) begin
      q_d    = start_new;
      mode_d = bus.mode;
    end else if (!q_legal) begin
      q_d   = start_cur;
      err_d = 1'b1;
    end else if (bus.en) begin
      q_d    = step_val;
      wrap_d = (step_val == start_cur);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= start_new;
      mode_q <= bus.mode;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.qbar = ~q_q;
  assign bus.idx  = idx_c;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_shift_ring_counter.sv
// -----------------------------------------------------------------------------
// tb_shift_ring_counter
// Drives three counters (WIDTH 4, 5, 2) from shared controls and compares
// each against a behavioural model after every clock edge.
// -----------------------------------------------------------------------------
module tb_shift_ring_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, dir, mode, load;
  logic [31:0] lv [3];

  int checks = 0;
  int errors = 0;

  int wid [3] = '{4, 5, 2};

  shift_ring_counter_if #(.WIDTH(4)) if0 ();
  shift_ring_counter_if #(.WIDTH(5)) if1 ();
  shift_ring_counter_if #(.WIDTH(2)) if2 ();

  shift_ring_counter #(.WIDTH(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
  shift_ring_counter #(.WIDTH(5)) u1 (.clk(clk), .rst(rst), .bus(if1));
  shift_ring_counter #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.en = en;   assign if0.dir = dir;  assign if0.mode = mode;
  assign if0.load = load; assign if0.load_val = lv[0][3:0];
  assign if1.en = en;   assign if1.dir = dir;  assign if1.mode = mode;
  assign if1.load = load; assign if1.load_val = lv[1][4:0];
  assign if2.en = en;   assign if2.dir = dir;  assign if2.mode = mode;
  assign if2.load = load; assign if2.load_val = lv[2][1:0];

  logic [31:0] oq [3], oqb [3], oidx [3];
  logic        ow [3], oe [3];

  assign oq[0] = 32'(if0.q); assign oqb[0] = 32'(if0.qbar); assign oidx[0] = 32'(if0.idx);
  assign oq[1] = 32'(if1.q); assign oqb[1] = 32'(if1.qbar); assign oidx[1] = 32'(if1.idx);
  assign oq[2] = 32'(if2.q); assign oqb[2] = 32'(if2.qbar); assign oidx[2] = 32'(if2.idx);
  assign ow[0] = if0.wrap; assign oe[0] = if0.err;
  assign ow[1] = if1.wrap; assign oe[1] = if1.err;
  assign ow[2] = if2.wrap; assign oe[2] = if2.err;

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] mq [3];
  logic        mmode [3], mwrap [3], merr [3];

  function automatic logic [31:0] msk(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int popc(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic m_legal(input logic [31:0] v, input int w, input logic md);
    logic [31:0] rot;
    rot = ((v >> 1) | (v << (w - 1))) & msk(w);
    if (md) return popc((v ^ rot) & msk(w)) <= 2;
    return popc(v & msk(w)) == 1;
  endfunction

  function automatic logic [31:0] m_start(input logic md);
    return md ? 32'd0 : 32'd1;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] v, input int w,
                                         input logic md, input logic d);
    logic [31:0] top, low;
    top = (v >> (w - 1)) & 32'd1;
    low = v & 32'd1;
    if (!d) return ((v << 1) & msk(w)) | (md ? (top ^ 32'd1) : top);
    return (v >> 1) | ((md ? (low ^ 32'd1) : low) << (w - 1));
  endfunction

  function automatic logic [31:0] m_idx(input logic [31:0] v, input int w, input logic md);
    int p;
    if (!m_legal(v, w, md)) return 32'd0;
    p = popc(v);
    if (!md) begin
      for (int i = 0; i < w; i++) if (v[i]) return 32'(i);
      return 32'd0;
    end
    return v[w-1] ? 32'(2 * w - p) : 32'(p);
  endfunction

  task automatic model_edge();
    logic [31:0] nx;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mq[k] = m_start(mode); mmode[k] = mode; mwrap[k] = 1'b0; merr[k] = 1'b0;
      end else begin
        mwrap[k] = 1'b0;
        merr[k]  = 1'b0;
        if (load) begin
          if (m_legal(lv[k] & msk(wid[k]), wid[k], mmode[k])) mq[k] = lv[k] & msk(wid[k]);
          else merr[k] = 1'b1;
        end else if (mode != mmode[k]) begin
          mq[k] = m_start(mode); mmode[k] = mode;
        end else if (!m_legal(mq[k], wid[k], mmode[k])) begin
          mq[k] = m_start(mmode[k]); merr[k] = 1'b1;
        end else if (en) begin
          nx = m_step(mq[k], wid[k], mmode[k], dir);
          mwrap[k] = (nx == m_start(mmode[k]));
          mq[k] = nx;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s w%0d q", tag, wid[k]),    oq[k],   mq[k]);
      chk($sformatf("%s w%0d qbar", tag, wid[k]), oqb[k],  ~mq[k] & msk(wid[k]));
      chk($sformatf("%s w%0d idx", tag, wid[k]),  oidx[k], m_idx(mq[k], wid[k], mmode[k]));
      chk($sformatf("%s w%0d wrap", tag, wid[k]), 32'(ow[k]), 32'(mwrap[k]));
      chk($sformatf("%s w%0d err", tag, wid[k]),  32'(oe[k]), 32'(merr[k]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_lv();
    lv[1] = $urandom;
    lv[2] = $urandom;
  endtask

  logic [31:0] e1 [4] = '{32'h2, 32'h4, 32'h8, 32'h1};
  logic [31:0] e2 [8] = '{32'h1, 32'h3, 32'h7, 32'hF, 32'hE, 32'hC, 32'h8, 32'h0};

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0;
    for (int k = 0; k < 3; k++) lv[k] = 32'd0;

    // reset
    tick("rst");
    tick("rst");
    chk("rst q4", oq[0], 32'h1);
    chk("rst wrap4", 32'(ow[0]), 32'd0);

    // ring up
    rst = 1'b0; en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("ring_up");
      chk("ring_up q4", oq[0], e1[i]);
      chk("ring_up idx4", oidx[0], 32'((i + 1) % 4));
      chk("ring_up wrap4", 32'(ow[0]), (i == 3) ? 32'd1 : 32'd0);
    end

    // Johnson up: mode change swallows the enable
    mode = 1'b1;
    tick("j_mode");
    chk("j_mode q4", oq[0], 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick("j_up");
      chk("j_up q4", oq[0], e2[i]);
      chk("j_up idx4", oidx[0], 32'((i + 1) % 8));
      chk("j_up wrap4", 32'(ow[0]), (i == 7) ? 32'd1 : 32'd0);
    end

    // ring down from 0100
    mode = 1'b0;
    tick("r_mode");
    tick("r_up");
    tick("r_up");
    chk("r_at4 q4", oq[0], 32'h4);
    dir = 1'b1;
    tick("r_dn"); chk("r_dn q4 a", oq[0], 32'h2);
    tick("r_dn"); chk("r_dn q4 b", oq[0], 32'h1); chk("r_dn wrap4 b", 32'(ow[0]), 32'd1);
    tick("r_dn"); chk("r_dn q4 c", oq[0], 32'h8); chk("r_dn wrap4 c", 32'(ow[0]), 32'd0);
    tick("r_dn"); chk("r_dn q4 d", oq[0], 32'h4);

    // Johnson down from 0011
    mode = 1'b1; dir = 1'b0;
    tick("j_mode2");
    tick("j_up2");
    tick("j_up2");
    chk("j_at3 q4", oq[0], 32'h3);
    dir = 1'b1;
    tick("j_dn"); chk("j_dn q4 a", oq[0], 32'h1);
    tick("j_dn"); chk("j_dn q4 b", oq[0], 32'h0); chk("j_dn wrap4", 32'(ow[0]), 32'd1);

    // loads in ring
    mode = 1'b0; dir = 1'b0;
    tick("l_mode");
    en = 1'b0; load = 1'b1; lv[0] = 32'h6; rand_lv();
    tick("l_bad");
    chk("l_bad q4", oq[0], 32'h1);
    chk("l_bad err4", 32'(oe[0]), 32'd1);
    en = 1'b1; lv[0] = 32'h8; rand_lv();
    tick("l_good");
    chk("l_good q4", oq[0], 32'h8);
    chk("l_good err4", 32'(oe[0]), 32'd0);
    load = 1'b0;
    tick("l_step");
    chk("l_step q4", oq[0], 32'h1);

    // mode change at 0100 with en high
    tick("m_up");
    tick("m_up");
    mode = 1'b1;
    tick("m_chg");
    chk("m_chg q4", oq[0], 32'h0);
    chk("m_chg wrap4", 32'(ow[0]), 32'd0);

    // Johnson loads: 0110 has two transitions, 0101 has four
    load = 1'b1; lv[0] = 32'h6; rand_lv();
    tick("jl_a");
    chk("jl_a q4", oq[0], 32'h6);
    lv[0] = 32'h5; rand_lv();
    tick("jl_b");
    chk("jl_b q4", oq[0], 32'h6);
    chk("jl_b err4", 32'(oe[0]), 32'd1);

    // reset mid-count overrides load and enable
    load = 1'b0;
    tick("pre_rst");
    tick("pre_rst");
    rst = 1'b1; load = 1'b1; lv[0] = 32'h8; rand_lv();
    tick("mid_rst");
    chk("mid_rst q4", oq[0], 32'h0);
    chk("mid_rst err4", 32'(oe[0]), 32'd0);
    mode = 1'b0;
    tick("mid_rst2");
    chk("mid_rst2 q4", oq[0], 32'h1);
    chk("mid_rst2 q5", oq[1], 32'h1);
    chk("mid_rst2 q2", oq[2], 32'h1);
    rst = 1'b0; load = 1'b0;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      en   = ($urandom_range(0, 3) != 0);
      dir  = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      load = ($urandom_range(0, 7) == 0);
      lv[0] = $urandom;
      rand_lv();
      rst  = ($urandom_range(0, 63) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
